// File: rtl/mem_stage_ls.sv
// MEM stage between EX and WB: waits on split-transaction data-SRAM responses,
// extracts and extends load data, buffers responses across WB stalls and drops stale ones.
module mem_stage_ls #(
    parameter int DW          = 32,
    parameter int MAX_DISCARD = 3
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           WB_allow,
    output logic           MEM_allow,
    input  logic           EX_to_MEM_valid,
    input  logic [DW+42:0] EX_to_MEM_bus,
    input  logic           flush,
    input  logic           data_sram_data_ok,
    input  logic [DW-1:0]  data_sram_rdata,
    output logic           MEM_to_WB_valid,
    output logic [DW+37:0] MEM_to_WB_bus,
    output logic [DW+6:0]  MEM_to_ID_forward
);
    localparam int OB    = $clog2(DW / 8);
    localparam int CNT_W = $clog2(MAX_DISCARD + 1);

    logic             mem_valid_q, mem_valid_d;
    logic [DW+42:0]   bus_q, bus_d;
    logic             resp_buf_valid_q, resp_buf_valid_d;
    logic [DW-1:0]    resp_buf_q, resp_buf_d;
    logic [CNT_W-1:0] discard_cnt_q, discard_cnt_d;

    logic          res_from_mem;
    logic [1:0]    ld_size;
    logic          ld_unsigned;
    logic          wait_resp;
    logic          gr_we;
    logic [4:0]    dest;
    logic [DW-1:0] alu_result;
    logic [31:0]   pc;

    assign res_from_mem = bus_q[DW+42];
    assign ld_size      = bus_q[DW+41:DW+40];
    assign ld_unsigned  = bus_q[DW+39];
    assign wait_resp    = bus_q[DW+38];
    assign gr_we        = bus_q[DW+37];
    assign dest         = bus_q[DW+36:DW+32];
    assign alu_result   = bus_q[DW+31:32];
    assign pc           = bus_q[31:0];

    logic got_resp;
    logic mem_ready_go;
    logic stale_inc;
    logic stale_dec;

    always_comb begin
        got_resp     = data_sram_data_ok && (discard_cnt_q == '0) && mem_valid_q
                       && wait_resp && !resp_buf_valid_q;
        mem_ready_go = !wait_resp || resp_buf_valid_q || got_resp;
        MEM_allow    = !mem_valid_q || (mem_ready_go && WB_allow);
        stale_inc    = flush && mem_valid_q && wait_resp && !resp_buf_valid_q && !got_resp;
        stale_dec    = data_sram_data_ok && (discard_cnt_q != '0);
    end

    // Flush beats acceptance; a response is buffered only while WB holds us off.
    always_comb begin
        mem_valid_d      = mem_valid_q;
        bus_d            = bus_q;
        resp_buf_valid_d = resp_buf_valid_q;
        resp_buf_d       = resp_buf_q;
        discard_cnt_d    = discard_cnt_q;

        if (flush) begin
            mem_valid_d      = 1'b0;
            resp_buf_valid_d = 1'b0;
        end else if (MEM_allow) begin
            mem_valid_d      = EX_to_MEM_valid;
            resp_buf_valid_d = 1'b0;
            if (EX_to_MEM_valid) begin
                bus_d = EX_to_MEM_bus;
            end
        end else if (got_resp) begin
            resp_buf_valid_d = 1'b1;
            resp_buf_d       = data_sram_rdata;
        end

        if (stale_inc && !stale_dec) begin
            if (discard_cnt_q != CNT_W'(MAX_DISCARD)) begin
                discard_cnt_d = discard_cnt_q + CNT_W'(1);
            end
        end else if (stale_dec && !stale_inc) begin
            discard_cnt_d = discard_cnt_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mem_valid_q      <= 1'b0;
            bus_q            <= '0;
            resp_buf_valid_q <= 1'b0;
            resp_buf_q       <= '0;
            discard_cnt_q    <= '0;
        end else begin
            mem_valid_q      <= mem_valid_d;
            bus_q            <= bus_d;
            resp_buf_valid_q <= resp_buf_valid_d;
            resp_buf_q       <= resp_buf_d;
            discard_cnt_q    <= discard_cnt_d;
        end
    end

    logic [DW-1:0] rd;
    logic [OB-1:0] off;
    logic [OB-1:0] off_al;
    logic [6:0]    lsh;
    logic [DW-1:0] shifted;
    logic [DW-1:0] left_just;
    logic [DW-1:0] ld_val;
    logic [DW-1:0] final_result;

    // Shift the addressed lane down, left-justify it, then shift back to extend.
    always_comb begin
        rd  = resp_buf_valid_q ? resp_buf_q : data_sram_rdata;
        off = alu_result[OB-1:0];
        case (ld_size)
            2'd0:    begin off_al = off;               lsh = 7'(DW - 8);  end
            2'd1:    begin off_al = off & ~OB'(1);     lsh = 7'(DW - 16); end
            2'd2:    begin off_al = off & ~OB'(3);     lsh = 7'(DW - 32); end
            default: begin off_al = '0;                lsh = 7'(0);       end
        endcase
        shifted   = rd >> {off_al, 3'b000};
        left_just = shifted << lsh;
        if (ld_unsigned) begin
            ld_val = left_just >> lsh;
        end else begin
            ld_val = $signed(left_just) >>> lsh;
        end
        final_result = res_from_mem ? ld_val : alu_result;
    end

    assign MEM_to_WB_valid   = mem_valid_q && mem_ready_go && !flush;
    assign MEM_to_WB_bus     = {gr_we, dest, final_result, pc};
    assign MEM_to_ID_forward = {gr_we && mem_valid_q, dest & {5{mem_valid_q}}, final_result,
                                mem_valid_q && res_from_mem && !mem_ready_go};

endmodule

// File: tb/tb_mem_stage_ls.sv
// Directed bench for mem_stage_ls: one 32-bit and one 64-bit instance, hand-computed results.
module tb_mem_stage_ls;
    logic clk;
    logic reset;

    logic         wb_allow32, ex_valid32, flush32, data_ok32;
    logic [74:0]  ex_bus32;
    logic [31:0]  rdata32;
    logic         mem_allow32, wbv32;
    logic [69:0]  wb32;
    logic [38:0]  fwd32;

    logic         wb_allow64, ex_valid64, flush64, data_ok64;
    logic [106:0] ex_bus64;
    logic [63:0]  rdata64;
    logic         mem_allow64, wbv64;
    logic [101:0] wb64;
    logic [70:0]  fwd64;

    int tests = 0;
    int fails = 0;

    mem_stage_ls #(.DW(32), .MAX_DISCARD(3)) u32 (
        .clk(clk), .reset(reset), .WB_allow(wb_allow32), .MEM_allow(mem_allow32),
        .EX_to_MEM_valid(ex_valid32), .EX_to_MEM_bus(ex_bus32), .flush(flush32),
        .data_sram_data_ok(data_ok32), .data_sram_rdata(rdata32),
        .MEM_to_WB_valid(wbv32), .MEM_to_WB_bus(wb32), .MEM_to_ID_forward(fwd32)
    );

    mem_stage_ls #(.DW(64), .MAX_DISCARD(3)) u64 (
        .clk(clk), .reset(reset), .WB_allow(wb_allow64), .MEM_allow(mem_allow64),
        .EX_to_MEM_valid(ex_valid64), .EX_to_MEM_bus(ex_bus64), .flush(flush64),
        .data_sram_data_ok(data_ok64), .data_sram_rdata(rdata64),
        .MEM_to_WB_valid(wbv64), .MEM_to_WB_bus(wb64), .MEM_to_ID_forward(fwd64)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // The stale counter must never be pushed past its ceiling.
    always @(posedge clk) begin
        if (!reset && u32.discard_cnt_q == 2'd3 && u32.stale_inc && !u32.stale_dec) begin
            fails++;
            $display("[TB] FAIL discard_overflow got cnt=%0d with increment, required no increment at 3",
                     u32.discard_cnt_q);
        end
    end

    function automatic logic [74:0] mk32(input logic rfm, input logic [1:0] sz, input logic uns,
                                         input logic wr, input logic gwe, input logic [4:0] dst,
                                         input logic [31:0] alu, input logic [31:0] pcv);
        return {rfm, sz, uns, wr, gwe, dst, alu, pcv};
    endfunction

    function automatic logic [106:0] mk64(input logic rfm, input logic [1:0] sz, input logic uns,
                                          input logic wr, input logic gwe, input logic [4:0] dst,
                                          input logic [63:0] alu, input logic [31:0] pcv);
        return {rfm, sz, uns, wr, gwe, dst, alu, pcv};
    endfunction

    task automatic issue32(input logic [74:0] b);
        @(negedge clk);
        ex_valid32 = 1'b1;
        ex_bus32   = b;
        @(posedge clk);
        #1 ex_valid32 = 1'b0;
    endtask

    task automatic issue64(input logic [106:0] b);
        @(negedge clk);
        ex_valid64 = 1'b1;
        ex_bus64   = b;
        @(posedge clk);
        #1 ex_valid64 = 1'b0;
    endtask

    task automatic test_reset;
        #3;
        tests++; if (wbv32 !== 1'b0) begin fails++; $display("[TB] FAIL reset_wbv got %b required 0", wbv32); end
        tests++; if (mem_allow32 !== 1'b1) begin fails++; $display("[TB] FAIL reset_allow got %b required 1", mem_allow32); end
        tests++; if (fwd32 !== 39'd0) begin fails++; $display("[TB] FAIL reset_fwd got %h required 0", fwd32); end
        tests++; if (fwd64 !== 71'd0) begin fails++; $display("[TB] FAIL reset_fwd64 got %h required 0", fwd64); end
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_byte_load;
        logic [31:0] exp_res [2];
        exp_res[0] = 32'hFFFF_FF80;
        exp_res[1] = 32'h0000_0080;
        for (int u = 0; u < 2; u++) begin
            issue32(mk32(1'b1, 2'd0, u[0], 1'b1, 1'b1, 5'd5, 32'h1003, 32'h100 + 32'(u)));
            @(negedge clk);
            data_ok32 = 1'b1;
            rdata32   = 32'h80AA_BBCC;
            #1;
            tests++; if (wbv32 !== 1'b1) begin fails++; $display("[TB] FAIL byte_valid[%0d] got %b required 1", u, wbv32); end
            tests++; if (wb32[63:32] !== exp_res[u]) begin fails++; $display("[TB] FAIL byte_result[%0d] got %h required %h", u, wb32[63:32], exp_res[u]); end
            tests++; if (wb32[69:64] !== 6'b1_00101 || wb32[31:0] !== 32'h100 + 32'(u)) begin
                fails++; $display("[TB] FAIL byte_fields[%0d] got %h required we/dest=25 pc=%h", u, wb32[69:64], 32'h100 + 32'(u));
            end
            @(posedge clk);
            #1 data_ok32 = 1'b0;
        end
    endtask

    task automatic test_delayed_half;
        issue32(mk32(1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 5'd7, 32'h2000, 32'h200));
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1;
            tests++; if (fwd32[0] !== 1'b1 || mem_allow32 !== 1'b0 || wbv32 !== 1'b0) begin
                fails++; $display("[TB] FAIL half_wait[%0d] got pend=%b allow=%b wbv=%b required 1 0 0", c, fwd32[0], mem_allow32, wbv32);
            end
        end
        @(negedge clk);
        data_ok32 = 1'b1;
        rdata32   = 32'h1234_8000;
        #1;
        tests++; if (wbv32 !== 1'b1 || wb32[63:32] !== 32'hFFFF_8000) begin
            fails++; $display("[TB] FAIL half_result got wbv=%b res=%h required 1 ffff8000", wbv32, wb32[63:32]);
        end
        tests++; if (fwd32 !== {1'b1, 5'd7, 32'hFFFF_8000, 1'b0}) begin
            fails++; $display("[TB] FAIL half_forward got %h required %h", fwd32, {1'b1, 5'd7, 32'hFFFF_8000, 1'b0});
        end
        @(posedge clk);
        #1 data_ok32 = 1'b0;
        issue32(mk32(1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 5'd7, 32'h2002, 32'h204));
        @(negedge clk);
        data_ok32 = 1'b1;
        #1;
        tests++; if (wb32[63:32] !== 32'h0000_1234) begin
            fails++; $display("[TB] FAIL half_upper got %h required 00001234", wb32[63:32]);
        end
        @(posedge clk);
        #1 data_ok32 = 1'b0;
    endtask

    task automatic test_wb_stall;
        wb_allow32 = 1'b0;
        issue32(mk32(1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 5'd9, 32'h3000, 32'h300));
        @(negedge clk);
        data_ok32 = 1'b1;
        rdata32   = 32'hDEAD_BEEF;
        #1;
        tests++; if (wbv32 !== 1'b1 || mem_allow32 !== 1'b0) begin
            fails++; $display("[TB] FAIL stall_first got wbv=%b allow=%b required 1 0", wbv32, mem_allow32);
        end
        @(posedge clk);
        #1;
        data_ok32 = 1'b0;
        rdata32   = 32'h0;
        @(negedge clk);
        tests++; if (u32.resp_buf_valid_q !== 1'b1 || wbv32 !== 1'b1 || wb32[63:32] !== 32'hDEAD_BEEF) begin
            fails++; $display("[TB] FAIL stall_buffered got bv=%b wbv=%b res=%h required 1 1 deadbeef", u32.resp_buf_valid_q, wbv32, wb32[63:32]);
        end
        @(negedge clk);
        wb_allow32 = 1'b1;
        ex_valid32 = 1'b1;
        ex_bus32   = mk32(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 5'd3, 32'h55, 32'h304);
        #1;
        tests++; if (wb32[63:32] !== 32'hDEAD_BEEF || mem_allow32 !== 1'b1) begin
            fails++; $display("[TB] FAIL stall_release got res=%h allow=%b required deadbeef 1", wb32[63:32], mem_allow32);
        end
        @(posedge clk);
        #1 ex_valid32 = 1'b0;
        @(negedge clk);
        tests++; if (u32.resp_buf_valid_q !== 1'b0 || wbv32 !== 1'b1 || wb32[63:32] !== 32'h55) begin
            fails++; $display("[TB] FAIL stall_next got bv=%b wbv=%b res=%h required 0 1 55", u32.resp_buf_valid_q, wbv32, wb32[63:32]);
        end
        @(posedge clk);
    endtask

    task automatic test_flush_discard;
        issue32(mk32(1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 5'd4, 32'h4000, 32'h400));
        @(negedge clk);
        flush32 = 1'b1;
        #1;
        tests++; if (wbv32 !== 1'b0) begin fails++; $display("[TB] FAIL flush_wbv got %b required 0", wbv32); end
        @(posedge clk);
        #1 flush32 = 1'b0;
        @(negedge clk);
        tests++; if (u32.discard_cnt_q !== 2'd1 || wbv32 !== 1'b0) begin
            fails++; $display("[TB] FAIL flush_cnt got cnt=%0d wbv=%b required 1 0", u32.discard_cnt_q, wbv32);
        end
        issue32(mk32(1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 5'd6, 32'h4004, 32'h404));
        @(negedge clk);
        data_ok32 = 1'b1;
        rdata32   = 32'h1111_1111;
        #1;
        tests++; if (wbv32 !== 1'b0 || fwd32[0] !== 1'b1) begin
            fails++; $display("[TB] FAIL stale_drop got wbv=%b pend=%b required 0 1", wbv32, fwd32[0]);
        end
        @(posedge clk);
        #1 data_ok32 = 1'b0;
        @(negedge clk);
        tests++; if (u32.discard_cnt_q !== 2'd0 || u32.resp_buf_valid_q !== 1'b0) begin
            fails++; $display("[TB] FAIL stale_cnt got cnt=%0d bv=%b required 0 0", u32.discard_cnt_q, u32.resp_buf_valid_q);
        end
        data_ok32 = 1'b1;
        rdata32   = 32'h2222_2222;
        #1;
        tests++; if (wbv32 !== 1'b1 || wb32[63:32] !== 32'h2222_2222) begin
            fails++; $display("[TB] FAIL fresh_deliver got wbv=%b res=%h required 1 22222222", wbv32, wb32[63:32]);
        end
        @(posedge clk);
        #1 data_ok32 = 1'b0;
        @(negedge clk);
        data_ok32 = 1'b1;
        #1;
        tests++; if (wbv32 !== 1'b0 || u32.discard_cnt_q !== 2'd0) begin
            fails++; $display("[TB] FAIL stray_ok got wbv=%b cnt=%0d required 0 0", wbv32, u32.discard_cnt_q);
        end
        @(posedge clk);
        #1 data_ok32 = 1'b0;
    endtask

    task automatic test_dw64;
        issue64(mk64(1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 5'd8, 64'h1004, 32'h500));
        @(negedge clk);
        data_ok64 = 1'b1;
        rdata64   = 64'h8000_0001_0000_0000;
        #1;
        tests++; if (wbv64 !== 1'b1 || wb64[95:32] !== 64'hFFFF_FFFF_8000_0001) begin
            fails++; $display("[TB] FAIL dw64_word got wbv=%b res=%h required 1 ffffffff80000001", wbv64, wb64[95:32]);
        end
        @(posedge clk);
        #1 data_ok64 = 1'b0;
        issue64(mk64(1'b1, 2'd3, 1'b0, 1'b1, 1'b1, 5'd8, 64'h1004, 32'h504));
        @(negedge clk);
        data_ok64 = 1'b1;
        rdata64   = 64'h8000_0001_0000_0000;
        #1;
        tests++; if (wb64[95:32] !== 64'h8000_0001_0000_0000) begin
            fails++; $display("[TB] FAIL dw64_dword got %h required 8000000100000000", wb64[95:32]);
        end
        @(posedge clk);
        #1 data_ok64 = 1'b0;
    endtask

    task automatic test_reset_midwait;
        issue32(mk32(1'b1, 2'd2, 1'b0, 1'b1, 1'b1, 5'd11, 32'h6000, 32'h600));
        @(negedge clk);
        #1;
        tests++; if (fwd32[0] !== 1'b1) begin fails++; $display("[TB] FAIL midwait_pend got %b required 1", fwd32[0]); end
        reset = 1'b1;
        #1;
        tests++; if (wbv32 !== 1'b0 || mem_allow32 !== 1'b1 || fwd32 !== 39'd0) begin
            fails++; $display("[TB] FAIL midwait_reset got wbv=%b allow=%b fwd=%h required 0 1 0", wbv32, mem_allow32, fwd32);
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        data_ok32 = 1'b1;
        rdata32   = 32'hCAFE_F00D;
        #1;
        tests++; if (wbv32 !== 1'b0) begin fails++; $display("[TB] FAIL post_reset_ok got %b required 0", wbv32); end
        @(posedge clk);
        #1 data_ok32 = 1'b0;
        @(negedge clk);
        tests++; if (wbv32 !== 1'b0 || u32.discard_cnt_q !== 2'd0) begin
            fails++; $display("[TB] FAIL post_reset_state got wbv=%b cnt=%0d required 0 0", wbv32, u32.discard_cnt_q);
        end
    endtask

    initial begin
        reset      = 1'b1;
        wb_allow32 = 1'b1; ex_valid32 = 1'b0; ex_bus32 = '0; flush32 = 1'b0; data_ok32 = 1'b0; rdata32 = '0;
        wb_allow64 = 1'b1; ex_valid64 = 1'b0; ex_bus64 = '0; flush64 = 1'b0; data_ok64 = 1'b0; rdata64 = '0;
        test_reset();
        test_byte_load();
        test_delayed_half();
        test_wb_stall();
        test_flush_discard();
        test_dw64();
        test_reset_midwait();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
